alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue pipeline stage that sits directly upstream of the 32-bit ALU. It accepts one RV32I integer instruction per cycle together with its register-file operands. It decodes the instruction into the ALU's 4-bit operation code and the A/B operands, and holds the result in a pipeline register with a two-entry skid buffer, so backpressure from execute never drops or reorders instructions.

## Interface
- XLEN, 32, datapath width of operands and instruction.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept; registered (equals "skid entry empty").
- instr  in  32  RV32I instruction word.
- rs1_data  in  32  register-file value for instr[19:15].
- rs2_data  in  32  register-file value for instr[24:20].
- flush  in  1  discard everything held and offered this cycle.
- out_valid  out  1  an issued op is presented to the ALU.
- out_ready  in  1  execute consumes the presented op.
- alu_a  out  32  ALU operand A.
- alu_b  out  32  ALU operand B.
- alu_kontrol  out  4  ALU operation code.
- rd  out  5  destination register, instr[11:7].
- wr_en  out  1  result must be written back (0 for illegal ops).
- illegal  out  1  instruction not supported by the ALU.

## Operation
- ALU op codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- R-type, opcode 0110011: A=rs1_data, B=rs2_data.
  - funct3 000 gives ADD, or SUB when instr[30]=1.
  - 111 AND; 110 OR; 100 XOR; 001 SLL.
  - 101 gives SRL, or SRA when instr[30]=1.
- I-type, opcode 0010011: A=rs1_data, B={{20{instr[31]}},instr[31:20]}.
  - funct3 maps as for R-type; instr[30] is ignored except for funct3 101.
  - For shifts B={27'b0,instr[24:20]}.
- LUI, opcode 0110111: A=0, B={instr[31:12],12'b0}, op LUI.
- Anything else is illegal, including funct3 010/011 (SLT/SLTU) and unknown opcodes.
  - Illegal ops still issue in order, with illegal=1, wr_en=0, alu_kontrol=0000, A=B=0.
- Decode is combinational on the input side. Decoded fields are registered into the main entry or the skid entry.
- Acceptance: a transfer occurs when in_valid && in_ready && !flush.
- Entry rules:
  - Main entry empty, or draining this cycle (out_ready=1): the accepted op loads main.
  - Main entry full and stalled: the accepted op loads the skid entry, and in_ready drops next cycle.
  - Main drains while skid is full: skid moves into main, skid clears, and in_ready rises next cycle.
- Simultaneous drain and accept with skid empty: new op loads main; out_valid stays 1.
- flush: out_valid, skid valid and illegal clear at the next edge; in_ready=1 next cycle.
  - Any op offered in the flush cycle is dropped.
  - flush overrides accept and skid moves.
- Output data fields are don't-care when out_valid=0.

## Timing
- Reset values (asynchronous, immediate):
  - out_valid=0, in_ready=1, wr_en=0, illegal=0.
  - alu_a=0, alu_b=0, alu_kontrol=0000, rd=0, skid valid=0.
- Latency: an accepted op appears on the outputs the cycle after acceptance (1 cycle), or later under stall.
- Throughput: one op per cycle while out_ready=1.
- in_ready is a flop output with no combinational path from out_ready.
- Capacity is two ops. A third op is not accepted until an entry frees.
- Order is strictly FIFO. No op is duplicated or lost except by flush.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset asserted mid-stall discards both entries.

## Test plan
- ADD x3,x1,x2: instr=0x002081B3, rs1=2, rs2=1 -> next cycle out_valid=1, kontrol=0000, A=2, B=1, rd=3, wr_en=1.
- SUB, instr=0x402081B3 -> kontrol=0100.
- SRAI x5,x6,16, instr=0x41035293 -> kontrol=1111, B=0x10.
- ADDI x1,x1,-1, instr=0xFFF08093 -> kontrol=0000, B=0xFFFFFFFF.
- LUI x7,0xFF005, instr=0xFF0053B7 -> kontrol=0110, A=0, B=0xFF005000, rd=7.
- Backpressure: hold out_ready=0 and offer SUB, AND and OR back-to-back.
  - SUB goes to main and AND to skid.
  - in_ready=0 from the third cycle; OR is held.
  - Release out_ready -> SUB, AND, OR emerge in order on consecutive cycles, none lost.
- Illegal SLT, instr=0x0020A1B3 -> issues with illegal=1, wr_en=0, kontrol=0000. A following ADD issues normally.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered op is never issued.
- Assert rst mid-stall -> outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the 32-bit ALU: decodes RV32I integer ops into
// ALU control plus operands and issues them through a main register and a one-entry skid.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_kontrol,
    output logic [4:0]      rd,
    output logic            wr_en,
    output logic            illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      kontrol;
        logic [4:0]      rd;
        logic            wr_en;
        logic            illegal;
    } issue_op_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_r;
    logic       w_is_shift;
    logic       w_f3_legal;
    logic [3:0] w_f3_op;
    issue_op_t  w_dec;
    logic       w_accept;

    issue_op_t  r_main;
    issue_op_t  r_skid;
    logic       r_out_valid;
    logic       r_skid_valid;
    logic       r_in_ready;

    assign w_opcode   = instr[6:0];
    assign w_funct3   = instr[14:12];
    assign w_is_r     = (w_opcode == OPC_R);
    assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);

    // instr[30] selects SUB only for register ops; for funct3 101 it selects SRA in both formats
    always_comb begin
        w_f3_legal = 1'b1;
        w_f3_op    = ALU_ADD;
        case (w_funct3)
            3'b000:  w_f3_op = (w_is_r && instr[30]) ? ALU_SUB : ALU_ADD;
            3'b111:  w_f3_op = ALU_AND;
            3'b110:  w_f3_op = ALU_OR;
            3'b100:  w_f3_op = ALU_XOR;
            3'b001:  w_f3_op = ALU_SLL;
            3'b101:  w_f3_op = instr[30] ? ALU_SRA : ALU_SRL;
            default: w_f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_dec    = '0;
        w_dec.rd = instr[11:7];
        case (w_opcode)
            OPC_R: begin
                if (w_f3_legal) begin
                    w_dec.a       = rs1_data;
                    w_dec.b       = rs2_data;
                    w_dec.kontrol = w_f3_op;
                    w_dec.wr_en   = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_I: begin
                if (w_f3_legal) begin
                    w_dec.a       = rs1_data;
                    w_dec.b       = w_is_shift ? {27'b0, instr[24:20]}
                                               : {{20{instr[31]}}, instr[31:20]};
                    w_dec.kontrol = w_f3_op;
                    w_dec.wr_en   = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                w_dec.a       = '0;
                w_dec.b       = {instr[31:12], 12'b0};
                w_dec.kontrol = ALU_LUI;
                w_dec.wr_en   = 1'b1;
            end
            default: w_dec.illegal = 1'b1;
        endcase
    end

    assign w_accept = in_valid && r_in_ready && !flush;

    // in_ready is kept as its own flop (always the inverse of skid occupancy) so it never sees out_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_out_valid    <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_in_ready     <= 1'b1;
            r_main.illegal <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end else if (w_accept) begin
                r_main      <= w_dec;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign alu_a       = r_main.a;
    assign alu_b       = r_main.b;
    assign alu_kontrol = r_main.kontrol;
    assign rd          = r_main.rd;
    assign wr_en       = r_main.wr_en;
    assign illegal     = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage: instructions are built from mnemonics and
// checked against an ISA-level expectation held in a two-slot FIFO model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_kontrol;
    logic [4:0]  rd;
    logic        wr_en;
    logic        illegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_kontrol(alu_kontrol), .rd(rd), .wr_en(wr_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  k;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } op_t;

    typedef enum int {M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLL, M_SRL, M_SRA} mnem_t;

    op_t q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] k,
                               input logic [4:0] rdv, input logic wr, input logic ill);
        op_t o;
        o.a = a; o.b = b; o.k = k; o.rd = rdv; o.wr = wr; o.ill = ill;
        return o;
    endfunction

    // ALU code each mnemonic must produce
    function automatic logic [3:0] alu_code(input mnem_t m);
        case (m)
            M_ADD:   return 4'b0000;
            M_SUB:   return 4'b0100;
            M_AND:   return 4'b0001;
            M_OR:    return 4'b0101;
            M_XOR:   return 4'b0010;
            M_SLL:   return 4'b0011;
            M_SRL:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] funct3_of(input mnem_t m);
        case (m)
            M_ADD, M_SUB: return 3'b000;
            M_AND:        return 3'b111;
            M_OR:         return 3'b110;
            M_XOR:        return 3'b100;
            M_SLL:        return 3'b001;
            default:      return 3'b101;
        endcase
    endfunction

    task automatic check_outputs();
        op_t e;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check_eq("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        if (q.size() != 0) begin
            e = q[0];
            check_eq("alu_a", alu_a, e.a);
            check_eq("alu_b", alu_b, e.b);
            check_eq("alu_kontrol", {28'b0, alu_kontrol}, {28'b0, e.k});
            check_eq("rd", {27'b0, rd}, {27'b0, e.rd});
            check_eq("wr_en", {31'b0, wr_en}, {31'b0, e.wr});
            check_eq("illegal", {31'b0, illegal}, {31'b0, e.ill});
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check_eq("rst_illegal", {31'b0, illegal}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_kontrol", {28'b0, alu_kontrol}, 32'd0);
        check_eq("rst_rd", {27'b0, rd}, 32'd0);
    endtask

    // One clock: check what is presented, drive inputs, then advance the FIFO model at the edge
    task automatic tick(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2, input op_t exp, input bit ordy, input bit fl);
        bit can_accept;
        @(negedge clk);
        check_outputs();
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            can_accept = (q.size() < 2);
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && can_accept) q.push_back(exp);
        end
        $display("[TB] cyc v=%0b instr=%08h ordy=%0b flush=%0b held=%0d", v, ins, ordy, fl, q.size());
    endtask

    task automatic gen_random(output logic [31:0] ins, output logic [31:0] r1,
                              output logic [31:0] r2, output op_t e);
        logic [4:0]  rdv, rs1f, rs2f, shamt;
        logic [11:0] imm;
        logic [19:0] u20;
        logic [2:0]  f3;
        logic [6:0]  opc;
        logic        b30;
        mnem_t       m;
        r1   = $urandom;
        r2   = $urandom;
        rdv  = 5'($urandom_range(0, 31));
        rs1f = 5'($urandom_range(0, 31));
        rs2f = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 5))
            0: begin
                m   = mnem_t'($urandom_range(0, 7));
                b30 = (m == M_SUB || m == M_SRA);
                ins = {1'b0, b30, 5'b0, rs2f, rs1f, funct3_of(m), rdv, 7'b0110011};
                e   = mk(r1, r2, alu_code(m), rdv, 1'b1, 1'b0);
            end
            1: begin
                case ($urandom_range(0, 3))
                    0: m = M_ADD;
                    1: m = M_XOR;
                    2: m = M_OR;
                    default: m = M_AND;
                endcase
                imm = 12'($urandom);
                ins = {imm, rs1f, funct3_of(m), rdv, 7'b0010011};
                e   = mk(r1, 32'($signed(imm)), alu_code(m), rdv, 1'b1, 1'b0);
            end
            2: begin
                case ($urandom_range(0, 2))
                    0: m = M_SLL;
                    1: m = M_SRL;
                    default: m = M_SRA;
                endcase
                shamt = 5'($urandom);
                b30   = (m == M_SRA) ? 1'b1 : (m == M_SLL) ? 1'($urandom) : 1'b0;
                ins   = {1'b0, b30, 5'b0, shamt, rs1f, funct3_of(m), rdv, 7'b0010011};
                e     = mk(r1, 32'(shamt), alu_code(m), rdv, 1'b1, 1'b0);
            end
            3: begin
                u20 = 20'($urandom);
                ins = {u20, rdv, 7'b0110111};
                e   = mk(32'd0, 32'(u20) * 32'd4096, 4'b0110, rdv, 1'b1, 1'b0);
            end
            4: begin
                f3  = $urandom_range(0, 1) != 0 ? 3'b010 : 3'b011;
                opc = $urandom_range(0, 1) != 0 ? 7'b0110011 : 7'b0010011;
                ins = {7'($urandom), rs2f, rs1f, f3, rdv, opc};
                e   = mk(32'd0, 32'd0, 4'd0, rdv, 1'b0, 1'b1);
            end
            default: begin
                ins = $urandom;
                while (ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0010011 || ins[6:0] == 7'b0110111)
                    ins = $urandom;
                e = mk(32'd0, 32'd0, 4'd0, ins[11:7], 1'b0, 1'b1);
            end
        endcase
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_SRAI = 32'h41035293;
    localparam logic [31:0] I_ADDI = 32'hFFF08093;
    localparam logic [31:0] I_LUI  = 32'hFF0053B7;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;

    initial begin
        op_t         none;
        op_t         e;
        logic [31:0] ins, r1, r2;
        none = '0;

        #1 rst = 1'b1;
        #1 check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        // Directed decode cases, full throughput
        tick(1, I_ADD,  32'd2,  32'd1, mk(32'd2, 32'd1, 4'b0000, 5'd3, 1, 0), 1, 0);
        tick(1, I_SUB,  32'd10, 32'd3, mk(32'd10, 32'd3, 4'b0100, 5'd3, 1, 0), 1, 0);
        tick(1, I_SRAI, 32'h80000000, 32'd0, mk(32'h80000000, 32'h10, 4'b1111, 5'd5, 1, 0), 1, 0);
        tick(1, I_ADDI, 32'd5,  32'd9, mk(32'd5, 32'hFFFFFFFF, 4'b0000, 5'd1, 1, 0), 1, 0);
        tick(1, I_LUI,  32'd77, 32'd88, mk(32'd0, 32'hFF005000, 4'b0110, 5'd7, 1, 0), 1, 0);
        tick(1, I_SLT,  32'd7,  32'd8, mk(32'd0, 32'd0, 4'b0000, 5'd3, 0, 1), 1, 0);
        tick(1, I_ADD,  32'd4,  32'd5, mk(32'd4, 32'd5, 4'b0000, 5'd3, 1, 0), 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);

        // Backpressure: SUB to main, AND to skid, OR held until space frees
        tick(1, I_SUB, 32'd20, 32'd6, mk(32'd20, 32'd6, 4'b0100, 5'd3, 1, 0), 0, 0);
        tick(1, I_AND, 32'hF0F0, 32'hFF00, mk(32'hF0F0, 32'hFF00, 4'b0001, 5'd3, 1, 0), 0, 0);
        tick(1, I_OR,  32'h1, 32'h2, mk(32'h1, 32'h2, 4'b0101, 5'd3, 1, 0), 0, 0);
        tick(1, I_OR,  32'h1, 32'h2, mk(32'h1, 32'h2, 4'b0101, 5'd3, 1, 0), 0, 0);
        tick(1, I_OR,  32'h1, 32'h2, mk(32'h1, 32'h2, 4'b0101, 5'd3, 1, 0), 1, 0);
        tick(1, I_OR,  32'h1, 32'h2, mk(32'h1, 32'h2, 4'b0101, 5'd3, 1, 0), 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);

        // Flush with both entries full and an op offered
        tick(1, I_ADD, 32'd1, 32'd1, mk(32'd1, 32'd1, 4'b0000, 5'd3, 1, 0), 0, 0);
        tick(1, I_SUB, 32'd2, 32'd2, mk(32'd2, 32'd2, 4'b0100, 5'd3, 1, 0), 0, 0);
        tick(1, I_OR,  32'd3, 32'd3, mk(32'd3, 32'd3, 4'b0101, 5'd3, 1, 0), 0, 1);
        tick(1, I_AND, 32'd4, 32'd6, mk(32'd4, 32'd6, 4'b0001, 5'd3, 1, 0), 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);
        tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);

        // Asynchronous reset in the middle of a stall
        tick(1, I_ADD, 32'd9, 32'd9, mk(32'd9, 32'd9, 4'b0000, 5'd3, 1, 0), 0, 0);
        tick(1, I_SUB, 32'd8, 32'd8, mk(32'd8, 32'd8, 4'b0100, 5'd3, 1, 0), 0, 0);
        #2;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst = 1'b1;
        #1 check_reset_values();
        q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            gen_random(ins, r1, r2, e);
            tick($urandom_range(0, 9) < 7, ins, r1, r2, e,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        for (int i = 0; i < 4; i++) tick(0, 32'd0, 32'd0, 32'd0, none, 1, 0);
        @(negedge clk);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
